data_mem_waitstate: RTL

- Data-memory responder on the memory-stage interface of the pipelined processor. It is the other end of the MemWriteM / DataAdrM / WriteDataM bus that `top` drives.
- Serves loads and stores from a word-organized array. Inserts a programmable number of wait states and signals them to the pipeline through a stall output.
- Provides byte-lane writes, out-of-range detection and a committed-write counter so benches can check store traffic without peeking inside the processor.

---
 rtl/data_mem_waitstate.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_mem_waitstate.sv
// Data-memory responder for the M stage: word array with byte-lane stores, programmable
// wait states signalled on StallM, out-of-range detection and a committed-store counter.
module data_mem_waitstate #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AddrErrM,
  output logic [31:0] WriteCount
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     adr_q, wd_q, rd_q, count_q;
  logic [3:0]      be_q;
  logic            wr_q;

  logic            req;
  logic            acc_valid, acc_wr, in_range, commit, load_done;
  logic [31:0]     acc_adr, acc_wd, rdata;
  logic [3:0]      acc_be;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH_WORDS];

  assign req = MemReadM | MemWriteM;

  // cnt_q holds the stall cycles still to come while in StWait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req && WAIT_CYCLES > 0) begin
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        adr_q <= DataAdrM;
        wd_q  <= WriteDataM;
        be_q  <= ByteEnM;
        wr_q  <= MemWriteM;
      end
      if (load_done) rd_q <= rdata;
      if (commit) count_q <= count_q + 32'd1;
    end
  end

  // With no wait states the access is served straight from the live bus.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_valid = (state_q == StIdle) && req;
      acc_adr   = DataAdrM;
      acc_wd    = WriteDataM;
      acc_be    = ByteEnM;
      acc_wr    = MemWriteM;
    end else begin
      acc_valid = (state_q == StDone);
      acc_adr   = adr_q;
      acc_wd    = wd_q;
      acc_be    = be_q;
      acc_wr    = wr_q;
    end
  end

  assign in_range  = (acc_adr[31:AW+2] == '0);
  assign idx       = acc_adr[AW+1:2];
  assign commit    = acc_valid && acc_wr && in_range && !reset;
  assign load_done = acc_valid && !acc_wr && !reset;
  assign rdata     = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wd[8*i +: 8];
      end
    end
  end

  assign ReadDataM  = load_done ? rdata : rd_q;
  assign AddrErrM   = acc_valid && !in_range && !reset;
  assign StallM     = !reset && ((state_q == StWait) ||
                                 (state_q == StIdle && req && WAIT_CYCLES > 0));
  assign WriteCount = count_q;

endmodule
